// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the icache-miss wait and
// registers the fetch-group descriptor for decode. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int unsigned GROUP_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] pred_pc_new,
    input  logic [2:0]  pred_valid_number,
    input  logic        icache_hit,
    input  logic        icache_refill_done,
    output logic [31:0] fetch_pc,
    output logic        fetch_en,
    output logic        icache_miss_req,
    output logic [31:0] icache_miss_addr,
    output logic        group_valid,
    output logic [31:0] group_pc,
    output logic [2:0]  group_count,
    output logic        flush,
    output logic [31:0] miss_count,
    output logic [31:0] redirect_count
);

    typedef enum logic [1:0] {StIdle, StRun, StMiss} state_e;

    state_e     state;
    logic [2:0] sat_count;

    // A count of 0 or above the ceiling means "full group".
    always_comb begin
        sat_count = pred_valid_number;
        if (pred_valid_number == 3'd0 || 32'(pred_valid_number) > GROUP_MAX) begin
            sat_count = 3'(GROUP_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            fetch_pc         <= RESET_PC;
            fetch_en         <= 1'b0;
            icache_miss_req  <= 1'b0;
            icache_miss_addr <= '0;
            group_valid      <= 1'b0;
            group_pc         <= '0;
            group_count      <= '0;
            flush            <= 1'b0;
        end else begin
            icache_miss_req <= 1'b0;
            flush           <= 1'b0;
            unique case (state)
                StIdle: begin
                    state    <= StRun;
                    fetch_en <= 1'b1;
                end
                StRun: begin
                    if (redirect_valid) begin
                        fetch_pc    <= {redirect_pc[31:2], 2'b00};
                        group_valid <= 1'b0;
                        flush       <= 1'b1;
                    end else if (!icache_hit) begin
                        state            <= StMiss;
                        fetch_en         <= 1'b0;
                        icache_miss_req  <= 1'b1;
                        icache_miss_addr <= {fetch_pc[31:4], 4'h0};
                        // A group decode is still holding survives the miss.
                        if (!stall) begin
                            group_valid <= 1'b0;
                        end
                    end else if (!stall) begin
                        group_valid <= 1'b1;
                        group_pc    <= fetch_pc;
                        group_count <= sat_count;
                        fetch_pc    <= pred_pc_new;
                    end
                end
                StMiss: begin
                    if (!stall) begin
                        group_valid <= 1'b0;
                    end
                    // Redirect retargets the PC but the outstanding refill still completes.
                    if (redirect_valid) begin
                        fetch_pc    <= {redirect_pc[31:2], 2'b00};
                        group_valid <= 1'b0;
                        flush       <= 1'b1;
                    end
                    if (icache_refill_done) begin
                        state    <= StRun;
                        fetch_en <= 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    fetch_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        redirect_take;
    logic        miss_take;
    logic [31:0] miss_cnt_q;
    logic [31:0] redirect_cnt_q;

    assign redirect_take = redirect_valid && (state == StRun || state == StMiss);
    assign miss_take     = (state == StRun) && !redirect_valid && !icache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q     <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (miss_take) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (redirect_take) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign miss_count     = miss_cnt_q;
    assign redirect_count = redirect_cnt_q;
`else
    assign miss_count     = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: expected groups are queued as advances are
// driven and popped when the descriptor appears one cycle later.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pred_pc_new;
    logic [2:0]  pred_valid_number;
    logic        icache_hit;
    logic        icache_refill_done;
    logic [31:0] fetch_pc;
    logic        fetch_en;
    logic        icache_miss_req;
    logic [31:0] icache_miss_addr;
    logic        group_valid;
    logic [31:0] group_pc;
    logic [2:0]  group_count;
    logic        flush;
    logic [31:0] miss_count;
    logic [31:0] redirect_count;

    fetch_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .pred_pc_new        (pred_pc_new),
        .pred_valid_number  (pred_valid_number),
        .icache_hit         (icache_hit),
        .icache_refill_done (icache_refill_done),
        .fetch_pc           (fetch_pc),
        .fetch_en           (fetch_en),
        .icache_miss_req    (icache_miss_req),
        .icache_miss_addr   (icache_miss_addr),
        .group_valid        (group_valid),
        .group_pc           (group_pc),
        .group_count        (group_count),
        .flush              (flush),
        .miss_count         (miss_count),
        .redirect_count     (redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cnt;
    } grp_t;

    grp_t        exp_q[$];
    logic [31:0] exp_pc;
    int          errors = 0;
    int          checks = 0;
    int          miss_pulses = 0;

    // One sample per cycle, well away from the active edge.
    always @(negedge clk) begin
        if (icache_miss_req) miss_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic hit, input logic rv,
                         input logic [31:0] rpc, input logic done);
        stall              = st;
        icache_hit         = hit;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        icache_refill_done = done;
    endtask

    task automatic advance(input logic [31:0] next_pc, input logic [2:0] n,
                           input logic [2:0] exp_n);
        grp_t e;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        pred_pc_new       = next_pc;
        pred_valid_number = n;
        exp_q.push_back({exp_pc, exp_n});
        step();
        e = exp_q.pop_front();
        check("grp_valid", 32'(group_valid), 32'd1);
        check("grp_pc", group_pc, e.pc);
        check("grp_count", 32'(group_count), 32'(e.cnt));
        exp_pc = next_pc;
        check("adv_fetch_pc", fetch_pc, exp_pc);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        pred_pc_new       = 32'h0;
        pred_valid_number = 3'd0;
        step();
        step();
        check("rst_fetch_pc", fetch_pc, 32'hBFC0_0000);
        check("rst_fetch_en", 32'(fetch_en), 32'd0);
        check("rst_group_valid", 32'(group_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_miss_req", 32'(icache_miss_req), 32'd0);
        check("rst_miss_addr", icache_miss_addr, 32'h0);
        rst = 1'b0;
        step();
        check("idle_to_run_en", 32'(fetch_en), 32'd1);
        exp_pc = 32'hBFC0_0000;

        // Sequential advance plus count saturation.
        advance(32'hBFC0_0010, 3'd4, 3'd4);
        advance(32'hBFC0_0020, 3'd4, 3'd4);
        advance(32'hBFC0_0030, 3'd0, 3'd4);
        advance(32'hBFC0_0040, 3'd7, 3'd4);
        advance(32'hBFC0_0048, 3'd2, 3'd2);

        // Redirect in RUN without stall.
        drive(1'b0, 1'b1, 1'b1, 32'h8000_1234, 1'b0);
        step();
        check("rd1_fetch_pc", fetch_pc, 32'h8000_1234);
        check("rd1_flush", 32'(flush), 32'd1);
        check("rd1_group_valid", 32'(group_valid), 32'd0);
        check("rd1_fetch_en", 32'(fetch_en), 32'd1);
        exp_pc = 32'h8000_1234;

        // Miss: one request pulse, wait, then re-fetch same PC.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("miss_req", 32'(icache_miss_req), 32'd1);
        check("miss_addr", icache_miss_addr, 32'h8000_1230);
        check("miss_fetch_en", 32'(fetch_en), 32'd0);
        check("miss_flush", 32'(flush), 32'd0);
        step();
        step();
        check("miss_wait_req", 32'(icache_miss_req), 32'd0);
        check("miss_wait_en", 32'(fetch_en), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check("refill_en", 32'(fetch_en), 32'd1);
        check("refill_pc", fetch_pc, 32'h8000_1234);
        check("miss_pulses1", 32'(miss_pulses), 32'd1);
        advance(32'h8000_1240, 3'd3, 3'd3);

        // Stall holds the group; redirect under stall.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            step();
            check("stall_valid", 32'(group_valid), 32'd1);
            check("stall_grp_pc", group_pc, 32'h8000_1234);
            check("stall_grp_cnt", 32'(group_count), 32'd3);
            check("stall_fetch_pc", fetch_pc, 32'h8000_1240);
        end
        drive(1'b1, 1'b1, 1'b1, 32'h8000_2003, 1'b0);
        step();
        check("rd2_fetch_pc", fetch_pc, 32'h8000_2000);
        check("rd2_flush", 32'(flush), 32'd1);
        check("rd2_group_valid", 32'(group_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        check("rd2_flush_pulse", 32'(flush), 32'd0);
        exp_pc = 32'h8000_2000;

        // Redirect coincident with refill completion.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("miss2_addr", icache_miss_addr, 32'h8000_2000);
        drive(1'b0, 1'b0, 1'b1, 32'h8000_3000, 1'b1);
        step();
        check("rd3_fetch_pc", fetch_pc, 32'h8000_3000);
        check("rd3_fetch_en", 32'(fetch_en), 32'd1);
        check("rd3_flush", 32'(flush), 32'd1);
        exp_pc = 32'h8000_3000;
        advance(32'h8000_3010, 3'd4, 3'd4);
        check("miss_pulses2", 32'(miss_pulses), 32'd2);
`ifdef FETCH_PERF_CNT_EN
        check("perf_miss_a", miss_count, 32'd2);
        check("perf_redir_a", redirect_count, 32'd3);
`else
        check("perf_miss_off", miss_count, 32'd0);
        check("perf_redir_off", redirect_count, 32'd0);
`endif

        // Asynchronous reset in the middle of a miss.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("miss3_req", 32'(icache_miss_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_fetch_pc", fetch_pc, 32'hBFC0_0000);
        check("arst_miss_req", 32'(icache_miss_req), 32'd0);
        check("arst_miss_addr", icache_miss_addr, 32'h0);
        check("arst_fetch_en", 32'(fetch_en), 32'd0);
        check("arst_miss_cnt", miss_count, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("rerun_en", 32'(fetch_en), 32'd1);
        check("rerun_group_pc", group_pc, 32'h0);

        // Two misses and one redirect after reset.
        step();
        check("miss4_addr", icache_miss_addr, 32'hBFC0_0000);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0105, 1'b0);
        step();
        check("rd4_fetch_pc", fetch_pc, 32'h0000_0104);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("miss5_addr", icache_miss_addr, 32'h0000_0100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
`ifdef FETCH_PERF_CNT_EN
        check("perf_miss_b", miss_count, 32'd2);
        check("perf_redir_b", redirect_count, 32'd1);
`else
        check("perf_miss_off_b", miss_count, 32'd0);
        check("perf_redir_off_b", redirect_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
